// File: rtl/simon_share_loader.sv
// simon_share_loader: captures two-share plaintext and key, streams them MSB
// first into a masked SIMON core (plaintext phase, then key phase), waits for
// the core to finish or time out, and captures the ciphertext.
module simon_share_loader #(
    parameter int LOAD_BITS   = 128,
    parameter int RUN_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] pt_a,
    input  logic [127:0] pt_b,
    input  logic [127:0] key_a,
    input  logic [127:0] key_b,
    output logic         data_ina,
    output logic         data_inb,
    output logic [1:0]   data_rdy,
    input  logic         core_done,
    input  logic [127:0] core_cipher,
    output logic         busy,
    output logic [127:0] result,
    output logic         result_valid,
    output logic         timeout
);

    // Last counter value of a load phase and of the RUN window.
    localparam logic [7:0] LOAD_LAST = 8'(LOAD_BITS - 1);
    localparam logic [7:0] RUN_LAST  = 8'(RUN_TIMEOUT - 1);

    // Core phase codes driven on data_rdy.
    localparam logic [1:0] PHASE_CLEAR = 2'd0;
    localparam logic [1:0] PHASE_PT    = 2'd1;
    localparam logic [1:0] PHASE_KEY   = 2'd2;
    localparam logic [1:0] PHASE_RUN   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PT,
        LOAD_KEY,
        RUN,
        FLUSH
    } state_t;

    state_t       state;
    logic [7:0]   bit_cnt;
    logic [127:0] sh_pt_a;
    logic [127:0] sh_pt_b;
    logic [127:0] sh_key_a;
    logic [127:0] sh_key_b;

    // Whole controller: the serial bit for the coming cycle is registered one
    // edge ahead, so the pt registers are captured already shifted by one and
    // the key MSBs are moved out on the edge that leaves LOAD_PT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 8'd0;
            data_rdy     <= PHASE_CLEAR;
            data_ina     <= 1'b0;
            data_inb     <= 1'b0;
            busy         <= 1'b0;
            result       <= 128'd0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            sh_pt_a      <= 128'd0;
            sh_pt_b      <= 128'd0;
            sh_key_a     <= 128'd0;
            sh_key_b     <= 128'd0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh_pt_a  <= {pt_a[126:0], 1'b0};
                        sh_pt_b  <= {pt_b[126:0], 1'b0};
                        sh_key_a <= key_a;
                        sh_key_b <= key_b;
                        data_ina <= pt_a[127];
                        data_inb <= pt_b[127];
                        bit_cnt  <= 8'd0;
                        data_rdy <= PHASE_PT;
                        busy     <= 1'b1;
                        state    <= LOAD_PT;
                    end
                end
                LOAD_PT: begin
                    if (bit_cnt == LOAD_LAST) begin
                        data_ina <= sh_key_a[127];
                        data_inb <= sh_key_b[127];
                        sh_key_a <= {sh_key_a[126:0], 1'b0};
                        sh_key_b <= {sh_key_b[126:0], 1'b0};
                        bit_cnt  <= 8'd0;
                        data_rdy <= PHASE_KEY;
                        state    <= LOAD_KEY;
                    end else begin
                        data_ina <= sh_pt_a[127];
                        data_inb <= sh_pt_b[127];
                        sh_pt_a  <= {sh_pt_a[126:0], 1'b0};
                        sh_pt_b  <= {sh_pt_b[126:0], 1'b0};
                        bit_cnt  <= bit_cnt + 8'd1;
                    end
                end
                LOAD_KEY: begin
                    if (bit_cnt == LOAD_LAST) begin
                        data_ina <= 1'b0;
                        data_inb <= 1'b0;
                        bit_cnt  <= 8'd0;
                        data_rdy <= PHASE_RUN;
                        state    <= RUN;
                    end else begin
                        data_ina <= sh_key_a[127];
                        data_inb <= sh_key_b[127];
                        sh_key_a <= {sh_key_a[126:0], 1'b0};
                        sh_key_b <= {sh_key_b[126:0], 1'b0};
                        bit_cnt  <= bit_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        result       <= core_cipher;
                        result_valid <= 1'b1;
                        bit_cnt      <= 8'd0;
                        data_rdy     <= PHASE_CLEAR;
                        state        <= FLUSH;
                    end else if (bit_cnt == RUN_LAST) begin
                        timeout  <= 1'b1;
                        bit_cnt  <= 8'd0;
                        data_rdy <= PHASE_CLEAR;
                        state    <= FLUSH;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    data_rdy <= PHASE_CLEAR;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_share_loader.sv
// tb_simon_share_loader: table-driven and randomized transactions, each checked
// cycle by cycle against an expected trace built from the share bits and the
// phase lengths, plus the captured result.
module tb_simon_share_loader;

    localparam int LB = 128;
    localparam int RT = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] pt_a;
    logic [127:0] pt_b;
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic         data_ina;
    logic         data_inb;
    logic [1:0]   data_rdy;
    logic         core_done;
    logic [127:0] core_cipher;
    logic         busy;
    logic [127:0] result;
    logic         result_valid;
    logic         timeout;

    simon_share_loader #(
        .LOAD_BITS   (LB),
        .RUN_TIMEOUT (RT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pt_a         (pt_a),
        .pt_b         (pt_b),
        .key_a        (key_a),
        .key_b        (key_b),
        .data_ina     (data_ina),
        .data_inb     (data_inb),
        .data_rdy     (data_rdy),
        .core_done    (core_done),
        .core_cipher  (core_cipher),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] rdy;
        logic       ina;
        logic       inb;
        logic       bsy;
        logic       rv;
        logic       to;
    } obs_t;

    typedef struct {
        string        name;
        logic [127:0] pa;
        logic [127:0] pb;
        logic [127:0] ka;
        logic [127:0] kb;
        int           done_at;
        int           stray_k;
        int           reset_run;
        bit           hold;
        int           exp_run;
        bit           exp_ok;
    } vec_t;

    int           n_compared = 0;
    int           n_failed   = 0;
    int           txn_fails  = 0;
    logic [127:0] exp_result = 128'd0;
    obs_t         exp_q[$];
    vec_t         tbl[9];

    function automatic obs_t sample_obs();
        obs_t o;
        o.rdy = data_rdy;
        o.ina = data_ina;
        o.inb = data_inb;
        o.bsy = busy;
        o.rv  = result_valid;
        o.to  = timeout;
        return o;
    endfunction

    function automatic obs_t mk(input logic [1:0] rdy, input logic ina, input logic inb,
                                input logic bsy, input logic rv, input logic to);
        obs_t o;
        o.rdy = rdy;
        o.ina = ina;
        o.inb = inb;
        o.bsy = bsy;
        o.rv  = rv;
        o.to  = to;
        return o;
    endfunction

    function automatic logic [127:0] core_model(input logic [127:0] pa, input logic [127:0] pb,
                                                input logic [127:0] ka, input logic [127:0] kb);
        logic [127:0] k;
        k = ka ^ kb;
        return (pa ^ pb) ^ {k[63:0], k[127:64]} ^ 128'h5A5A_0000_FFFF_1234_0F0F_C3C3_9999_7E7E;
    endfunction

    // Expected per-cycle trace after accept: pt bits, key bits, RUN, FLUSH, IDLE.
    function automatic void build_expected(input vec_t v, input int reset_k);
        exp_q.delete();
        for (int i = 0; i < LB; i++) exp_q.push_back(mk(2'd1, v.pa[127-i], v.pb[127-i], 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < LB; i++) exp_q.push_back(mk(2'd2, v.ka[127-i], v.kb[127-i], 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < v.exp_run; i++) exp_q.push_back(mk(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, v.exp_ok, !v.exp_ok));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (reset_k > 0) begin
            while (exp_q.size() > reset_k) void'(exp_q.pop_back());
            exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endfunction

    task automatic check_output(input string what, input logic [127:0] actual, input logic [127:0] required);
        n_compared++;
        if (actual !== required) begin
            n_failed++;
            txn_fails++;
            $display("[TB] FAIL %s: got %h, want %h", what, actual, required);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [127:0] cipher;
        logic [127:0] prev_res;
        logic [127:0] new_res;
        logic [127:0] want_res;
        int           done_k;
        int           reset_k;
        int           res_from;
        int           n;
        cipher  = core_model(v.pa, v.pb, v.ka, v.kb);
        done_k  = (v.done_at >= 0) ? 2 * LB + v.done_at + 1 : 0;
        reset_k = (v.reset_run > 0) ? 2 * LB + v.reset_run : 0;
        build_expected(v, reset_k);
        n        = exp_q.size();
        prev_res = exp_result;
        if (reset_k > 0) begin
            new_res  = 128'd0;
            res_from = reset_k + 1;
        end else begin
            new_res  = v.exp_ok ? cipher : prev_res;
            res_from = n - 1;
        end
        txn_fails   = 0;
        pt_a        = v.pa;
        pt_b        = v.pb;
        key_a       = v.ka;
        key_b       = v.kb;
        core_cipher = cipher;
        start       = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check_output($sformatf("%s c%0d trace", v.name, k), 128'(sample_obs()), 128'(exp_q[k-1]));
            want_res = (k >= res_from) ? new_res : prev_res;
            if (k >= res_from - 1) check_output($sformatf("%s c%0d result", v.name, k), result, want_res);
            core_done = (k == done_k) || (k == v.stray_k);
            rst       = (reset_k > 0) && (k == reset_k);
            start     = v.hold || rst;
            if (txn_fails >= 8) begin
                $display("[TB] resync after repeated errors in %s", v.name);
                core_done = 1'b0;
                start     = 1'b0;
                rst       = 1'b1;
                repeat (2) @(negedge clk);
                rst        = 1'b0;
                exp_result = 128'd0;
                return;
            end
        end
        exp_result = new_res;
    endtask

    // Safety net so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset checks, vector table, then randomized transactions.
    initial begin
        vec_t v;
        tbl[0] = '{"single", 128'h0123456789ABCDEF0123456789ABCDEF, 128'd0,
                   128'h0F0E0D0C0B0A09080706050403020100, 128'd0, 136, 0, 0, 1'b0, 137, 1'b1};
        tbl[1] = '{"serial", 128'h80000000000000000000000000000001, 128'hFFFF0000FFFF0000FFFF0000FFFF0000,
                   128'hDEADBEEF00000000CAFEF00D12345678, 128'h00000000000000000000000000000003, 10, 0, 0, 1'b0, 11, 1'b1};
        tbl[2] = '{"timeout", 128'h1111222233334444555566667777888A, 128'h0,
                   128'h0, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, -1, 0, 0, 1'b0, 255, 1'b0};
        tbl[3] = '{"tie", 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 128'h3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C,
                   128'h0123456789ABCDEFFEDCBA9876543210, 128'h1, 254, 0, 0, 1'b0, 255, 1'b1};
        tbl[4] = '{"stray", 128'h00000000FFFFFFFF00000000FFFFFFFF, 128'h5,
                   128'h8000000000000000000000000000ABCD, 128'h7, 0, LB + 5, 0, 1'b0, 1, 1'b1};
        tbl[5] = '{"b2b_1", 128'hF0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0, 128'h9,
                   128'h13579BDF2468ACE013579BDF2468ACE0, 128'h0, 5, 0, 0, 1'b1, 6, 1'b1};
        tbl[6] = '{"b2b_2", 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 128'h6,
                   128'hFEDCBA98765432100123456789ABCDEF, 128'h8, 20, 0, 0, 1'b1, 21, 1'b1};
        tbl[7] = '{"midrst", 128'h77777777777777777777777777777777, 128'h1,
                   128'h2, 128'h3, -1, 0, 50, 1'b0, 255, 1'b0};
        tbl[8] = '{"after_rst", 128'hCAFEBABECAFEBABECAFEBABECAFEBABE, 128'h12345,
                   128'h0BADF00D0BADF00D0BADF00D0BADF00D, 128'h0, 30, 0, 0, 1'b0, 31, 1'b1};

        rst         = 1'b1;
        start       = 1'b1;
        core_done   = 1'b1;
        pt_a        = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
        pt_b        = 128'd0;
        key_a       = 128'd0;
        key_b       = 128'd0;
        core_cipher = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_output("reset trace", 128'(sample_obs()), 128'd0);
            check_output("reset result", result, 128'd0);
        end
        rst       = 1'b0;
        start     = 1'b0;
        core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("idle trace", 128'(sample_obs()), 128'd0);
            check_output("idle result", result, 128'd0);
        end

        for (int t = 0; t < 9; t++) apply_stimulus(tbl[t]);

        for (int r = 0; r < 8; r++) begin
            v.name      = $sformatf("rand%0d", r);
            v.pa        = {$urandom(), $urandom(), $urandom(), $urandom()};
            v.pb        = {$urandom(), $urandom(), $urandom(), $urandom()};
            v.ka        = {$urandom(), $urandom(), $urandom(), $urandom()};
            v.kb        = {$urandom(), $urandom(), $urandom(), $urandom()};
            v.done_at   = int'($urandom_range(0, 300));
            v.stray_k   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * LB)) : 0;
            v.reset_run = 0;
            v.hold      = ($urandom_range(0, 3) == 0);
            if (v.done_at < RT) begin
                v.exp_run = v.done_at + 1;
                v.exp_ok  = 1'b1;
            end else begin
                v.exp_run = RT;
                v.exp_ok  = 1'b0;
            end
            apply_stimulus(v);
        end

        start = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
